disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
Time-multiplexed display scanner that sits directly upstream of the hex-to-seven-segment decoder. It captures a multi-digit hex value and scans the digits one at a time. For each digit slot it presents the 4-bit nibble to the decoder and drives a one-hot digit enable. It also provides leading-zero blanking, a per-digit decimal point, and an anti-ghosting guard interval at every digit change.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clock cycles per digit slot (>= 2)
GUARD, 2, cycles at the start of each slot during which all enables are off (0 <= GUARD < PRESCALE)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
value  input  4*DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
dp_in  input  DIGITS  decimal point request per digit
load  input  1  single-cycle capture strobe for value and dp_in
blank_lz  input  1  1 = blank leading zeros
hex  output  4  nibble for the decoder's hex input
an  output  DIGITS  one-hot digit enable, active-high
blank  output  1  1 = downstream forces all segments off
dp  output  1  decimal point for the currently enabled digit
slot_tick  output  1  one-cycle pulse at the first cycle of each new slot

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1, these all clear: shadow value, shadow dp, prescaler cnt, digit index idx.
- Output reset values: hex=0, an=0, blank=1, dp=0, slot_tick=0.
- Capture:
  - When load=1 at a clock edge, value and dp_in are copied to shadow registers atomically.
  - All digits use the new shadow from the next cycle; a scan never mixes old and new digits.
  - load held high recaptures every cycle.
  - With no load, the shadow holds indefinitely.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - When cnt=PRESCALE-1, idx advances: idx+1, and DIGITS-1 wraps to 0.
  - Scan order is 0,1,...,DIGITS-1,0,...
- Registered outputs: all outputs are registered and computed from the state (cnt, idx, shadow) of the previous cycle, giving a fixed 1-cycle latency.
- Guard interval: when cnt < GUARD, an=0 and blank=1, while hex still carries the idx nibble.
- Active window (cnt >= GUARD): an = onehot(idx) unless the digit is blanked.
- Leading-zero blanking:
  - Digit idx is blanked when blank_lz=1, idx != 0, and shadow digits idx..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit gives an=0, blank=1, hex=0, dp=0.
  - blank_lz is sampled live, not captured by load.
- dp: equals shadow dp[idx] when the digit is enabled, otherwise 0. A dp on a leading-zero-blanked digit is suppressed.
- slot_tick: equals 1 on the output cycle where cnt=0.
- Onehot guarantee: an is never more than one-hot in any cycle, including across load and wrap.
- Reset mid-scan: immediate return to idx=0, cnt=0. After release, scanning restarts at digit 0 with a full guard interval.
- Simultaneous load and slot change: the new digit is shown using the new shadow value.

Test Plan:
(Bench uses DIGITS=4, PRESCALE=8, GUARD=2.)
1. Reset, then load value=16'h12A5, dp_in=4'b0000, blank_lz=0 -> per 8-cycle slot, an=0 for 2 cycles, then 0001/0010/0100/1000 for 6 cycles with hex=5,A,2,1. slot_tick every 8 cycles; full scan period 32 cycles.
2. Load 16'h00A5, blank_lz=1 -> digits 0,1 show 5 and A. Digits 2,3 give an=0, blank=1, hex=0 throughout. Set blank_lz=0 -> digits 2,3 show hex=0 with an asserted.
3. Load 16'h0000, blank_lz=1, dp_in=4'b0101 -> only digit 0 is enabled, hex=0, dp=1. Digit 2's dp is suppressed; an stays 0 in slots 1..3.
4. Load 16'h1111, then load 16'h2222 mid-slot of digit 1 -> hex changes to 2 one cycle after the load edge. No slot ever shows mixed digits; an is never multi-hot.
5. Assert rst asynchronously mid-slot at idx=2 -> outputs go to reset values without a clock edge. After release, the first enabled an=0001 appears on output cycle GUARD+1 and shadow=0.
6. Load at the same edge as cnt=7 wrap -> the next slot's hex reflects the newly loaded digit, and slot_tick=1 on that cycle.

Source files
------------

// File: rtl/disp_scan.sv
// Time-multiplexed hex display scanner feeding a seven-segment decoder.
// Captures a multi-digit value, then scans digits with guard, blanking and dp.
module disp_scan #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [3:0]            hex,
    output logic [DIGITS-1:0]     an,
    output logic                  blank,
    output logic                  dp,
    output logic                  slot_tick
);

    localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [3:0]          hex_c;
    logic [DIGITS-1:0]   an_c;
    logic                blank_c;
    logic                dp_c;
    logic                tick_c;
    logic [3:0]          digit_c;
    logic                lz_c;
    logic                in_guard_c;

    // Shadow capture and slot prescaler / digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next output values from the current scan state
    always_comb begin
        digit_c    = shadow_val[{idx, 2'b00} +: 4];
        in_guard_c = (cnt < CNT_GUARD);
        tick_c     = (cnt == '0);

        // A digit is a leading zero when it and every digit above it are zero
        lz_c = blank_lz && (idx != '0);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((IDX_W'(i) >= idx) && (shadow_val[4*i +: 4] != 4'h0)) begin
                lz_c = 1'b0;
            end
        end

        an_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            an_c[i] = (idx == IDX_W'(i));
        end

        hex_c   = digit_c;
        blank_c = 1'b0;
        dp_c    = shadow_dp[idx];
        if (lz_c) begin
            hex_c   = 4'h0;
            an_c    = '0;
            blank_c = 1'b1;
            dp_c    = 1'b0;
        end else if (in_guard_c) begin
            an_c    = '0;
            blank_c = 1'b1;
            dp_c    = 1'b0;
        end
    end

    // Output registers give a fixed one-cycle latency from scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex       <= 4'h0;
            an        <= '0;
            blank     <= 1'b1;
            dp        <= 1'b0;
            slot_tick <= 1'b0;
        end else begin
            hex       <= hex_c;
            an        <= an_c;
            blank     <= blank_c;
            dp        <= dp_c;
            slot_tick <= tick_c;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIGITS=4, PRESCALE=8, GUARD=2.
module tb_disp_scan;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 8;
    localparam int unsigned GUARD    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        blank;
    logic        dp;
    logic        slot_tick;

    int n_checks = 0;
    int n_fail   = 0;

    disp_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .hex(hex), .an(an), .blank(blank), .dp(dp),
        .slot_tick(slot_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_hex, input logic [3:0] e_an,
                             input logic e_blank, input logic e_dp, input logic e_tick);
        chk({tag, " hex"},   16'(hex),       16'(e_hex));
        chk({tag, " an"},    16'(an),        16'(e_an));
        chk({tag, " blank"}, 16'(blank),     16'(e_blank));
        chk({tag, " dp"},    16'(dp),        16'(e_dp));
        chk({tag, " tick"},  16'(slot_tick), 16'(e_tick));
        chk({tag, " onehot"}, 16'($countones(an) <= 1), 16'd1);
    endtask

    // One full 8-cycle slot; optional load lands on the wrap edge
    task automatic run_slot(input string tag, input logic [3:0] e_hex, input logic [3:0] e_an,
                            input logic e_dp, input logic ld, input logic [15:0] ld_val,
                            input logic [3:0] ld_dp);
        logic en;
        for (int c = 0; c < int'(PRESCALE); c++) begin
            @(posedge clk);
            @(negedge clk);
            en = (c >= int'(GUARD)) && (e_an != 4'b0);
            check_out($sformatf("%s c%0d", tag, c), e_hex, en ? e_an : 4'b0, !en,
                      en ? e_dp : 1'b0, c == 0);
            if (ld && c == int'(PRESCALE) - 2) begin
                load  = 1'b1;
                value = ld_val;
                dp_in = ld_dp;
            end
            if (c == int'(PRESCALE) - 1) load = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic scan, load at the wrap edge of the first slot
        run_slot("rel_d0", 4'h0, 4'b0001, 1'b0, 1'b1, 16'h12A5, 4'b0000);
        run_slot("s1_d1",  4'hA, 4'b0010, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("s1_d2",  4'h2, 4'b0100, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("s1_d3",  4'h1, 4'b1000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("s1_d0",  4'h5, 4'b0001, 1'b0, 1'b1, 16'h00A5, 4'b0000);

        // Leading-zero blanking on, then off
        blank_lz = 1'b1;
        run_slot("lz_d1",  4'hA, 4'b0010, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("lz_d2",  4'h0, 4'b0000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("lz_d3",  4'h0, 4'b0000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("lz_d0",  4'h5, 4'b0001, 1'b0, 1'b0, 16'h0, 4'b0);
        blank_lz = 1'b0;
        run_slot("nolz_d1", 4'hA, 4'b0010, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("nolz_d2", 4'h0, 4'b0100, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("nolz_d3", 4'h0, 4'b1000, 1'b0, 1'b1, 16'h0000, 4'b0101);

        // All-zero value: only digit 0 shows, dp on digit 2 suppressed
        blank_lz = 1'b1;
        run_slot("zero_d0", 4'h0, 4'b0001, 1'b1, 1'b0, 16'h0, 4'b0);
        run_slot("zero_d1", 4'h0, 4'b0000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("zero_d2", 4'h0, 4'b0000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("zero_d3", 4'h0, 4'b0000, 1'b0, 1'b1, 16'h1111, 4'b0000);
        blank_lz = 1'b0;
        run_slot("ones_d0", 4'h1, 4'b0001, 1'b0, 1'b0, 16'h0, 4'b0);

        // Mid-slot reload during digit 1
        for (int c = 0; c < int'(PRESCALE); c++) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("midld c%0d", c), (c <= 4) ? 4'h1 : 4'h2,
                      (c >= int'(GUARD)) ? 4'b0010 : 4'b0000, c < int'(GUARD), 1'b0, c == 0);
            if (c == 3) begin
                load  = 1'b1;
                value = 16'h2222;
                dp_in = 4'b0000;
            end
            if (c == 4) load = 1'b0;
        end

        // Asynchronous reset in the middle of the digit 2 slot
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("prerst c%0d", c), 4'h2,
                      (c >= int'(GUARD)) ? 4'b0100 : 4'b0000, c < int'(GUARD), 1'b0, c == 0);
        end
        #1 rst = 1'b1;
        #1 check_out("async_rst", 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_out("rst_hold", 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        run_slot("post_d0", 4'h0, 4'b0001, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("post_d1", 4'h0, 4'b0010, 1'b0, 1'b1, 16'h7BCD, 4'b0100);

        // Load coinciding with the wrap is visible in the very next slot
        run_slot("wrap_d2", 4'hB, 4'b0100, 1'b1, 1'b0, 16'h0, 4'b0);
        run_slot("wrap_d3", 4'h7, 4'b1000, 1'b0, 1'b0, 16'h0, 4'b0);
        run_slot("wrap_d0", 4'hD, 4'b0001, 1'b0, 1'b0, 16'h0, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
